fpga_bitserial_adder_ctrl: RTL and testbench

//  Sequences one fpga_carry_logic cell as a bit-serial WIDTH-bit adder/subtractor.

---
 rtl/fpga_carry_pkg.sv | 21 ++
 rtl/fpga_carry_logic.sv | 15 +
 rtl/fpga_bitserial_adder_ctrl.sv | 125 ++++++++++++
 tb/tb_fpga_bitserial_adder_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_carry_pkg.sv
// Shared types and constants for the bit-serial carry-cell controller.
//   carry_ctrl_state_e : controller FSM state
//   WIDTH_MIN/WIDTH_MAX: legal operand width range
//   cnt_width()        : bit-counter width for a given operand width
package fpga_carry_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } carry_ctrl_state_e;

  localparam int unsigned WIDTH_MIN = 1;
  localparam int unsigned WIDTH_MAX = 64;

  // Counter must index bits 0..w-1; a 1-bit counter is kept even for w=1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fpga_carry_logic.sv
// Single carry cell: carry-out is the majority of the two data bits and
// the incoming carry.
//   i0, i1 : data bits
//   fcin   : carry in
//   fcout  : carry out
module fpga_carry_logic (
  input  logic i0,
  input  logic i1,
  input  logic fcin,
  output logic fcout
);

  assign fcout = (i0 & i1) | (i0 & fcin) | (i1 & fcin);

endmodule

// File: rtl/fpga_bitserial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor built around one carry cell.
// Operands are shifted LSB-first through the cell; a carry flop closes the
// fcout->fcin loop and the sum bit is formed locally.
//   clk_i, rst_ni            : clock, async active-low reset
//   req_valid_i/req_ready_o  : request handshake (ready only in IDLE)
//   a_i, b_i, cin_i, sub_i   : operands, carry-in, subtract select
//   rsp_valid_o/rsp_ready_i  : response handshake (valid held until taken)
//   sum_o, cout_o, ovf_o     : result, MSB carry-out, signed overflow
//   busy_o                   : operation in progress (RUN or DONE)
module fpga_bitserial_adder_ctrl
  import fpga_carry_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("fpga_bitserial_adder_ctrl: WIDTH out of range");
  end

  carry_ctrl_state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [CNT_W-1:0] bit_cnt;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  logic             fcout;
  logic             sum_bit;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum_nx;
  logic             last_bit;

  // The one carry cell, fed from the shift-register LSBs and the carry flop.
  fpga_carry_logic u_cell (
    .i0    (a_sh[0]),
    .i1    (b_sh[0]),
    .fcin  (carry_q),
    .fcout (fcout)
  );

  // Sum bit enters at the MSB; the concatenation keeps WIDTH=1 legal.
  assign sum_bit  = a_sh[0] ^ b_sh[0] ^ carry_q;
  assign sum_ext  = {sum_bit, sum_sh};
  assign sum_nx   = sum_ext[WIDTH:1];
  assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid_i) state_d = RUN;
      RUN:     if (last_bit)    state_d = DONE;
      DONE:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and serial datapath.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      bit_cnt <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            a_sh    <= a_i;
            b_sh    <= b_i ^ {WIDTH{sub_i}};
            carry_q <= cin_i ^ sub_i;
            bit_cnt <= '0;
          end
        end
        RUN: begin
          sum_sh  <= sum_nx;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          carry_q <= fcout;
          if (last_bit) begin
            // carry_q here is the carry into the MSB, fcout the carry out of it.
            sum_q  <= sum_nx;
            cout_q <= fcout;
            ovf_q  <= carry_q ^ fcout;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign rsp_valid_o = (state_q == DONE);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_fpga_bitserial_adder_ctrl.sv
// Self-checking bench for fpga_bitserial_adder_ctrl (WIDTH=8): directed cases,
// backpressure, mid-run reset and randomized operations against a reference model.
module tb_fpga_bitserial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         cin_i = 1'b0;
  logic         sub_i = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] sum_o;
  logic         cout_o, ovf_o, busy_o;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  fpga_bitserial_adder_ctrl #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .a_i         (a_i),
    .b_i         (b_i),
    .cin_i       (cin_i),
    .sub_i       (sub_i),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .sum_o       (sum_o),
    .cout_o      (cout_o),
    .ovf_o       (ovf_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    else n_pass++;
  endtask

  // Reference arithmetic: full-width two's-complement add of a and (possibly inverted) b.
  function automatic logic [W+1:0] ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin, input logic sub);
    logic [W-1:0] bx;
    logic [W:0]   t;
    logic         ovf;
    bx  = sub ? ~b : b;
    t   = {1'b0, a} + {1'b0, bx} + (W+1)'(cin ^ sub);
    ovf = (a[W-1] == bx[W-1]) && (t[W-1] != a[W-1]);
    return {ovf, t[W], t[W-1:0]};
  endfunction

  // Transaction-level model: busy for W run edges after a handshake, then valid until taken.
  logic         m_busy = 1'b0, m_valid = 1'b0;
  int           m_cnt = 0;
  logic [W+1:0] m_pend = '0;
  logic [W+1:0] m_out  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= 0; m_pend <= '0; m_out <= '0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= W;
        m_pend <= ref_calc(a_i, b_i, cin_i, sub_i);
      end
    end else if (!m_valid) begin
      if (m_cnt == 1) begin
        m_valid <= 1'b1;
        m_out   <= m_pend;
      end
      m_cnt <= m_cnt - 1;
    end else if (rsp_ready) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    chk("req_ready", 64'(req_ready), 64'(!m_busy));
    chk("busy",      64'(busy_o),    64'(m_busy));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    chk("sum",       64'(sum_o),     64'(m_out[W-1:0]));
    chk("cout",      64'(cout_o),    64'(m_out[W]));
    chk("ovf",       64'(ovf_o),     64'(m_out[W+1]));
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub, output int hs);
    @(posedge clk); #1;
    req_valid = 1'b1; a_i = a; b_i = b; cin_i = cin; sub_i = sub;
    hs = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready) begin hs = cyc; break; end
    end
    if (hs < 0) chk("req_ready_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom); sub_i = 1'($urandom);
  endtask

  task automatic wait_valid(input int hs, output int lat);
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = cyc - hs; break; end
    end
    if (lat < 0) chk("rsp_valid_timeout", 64'(0), 64'(1));
  endtask

  task automatic release_rsp();
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic check_res(input string nm, input logic [W-1:0] s, input logic c, input logic v);
    chk({nm, "_sum"},  64'(sum_o),  64'(s));
    chk({nm, "_cout"}, 64'(cout_o), 64'(c));
    chk({nm, "_ovf"},  64'(ovf_o),  64'(v));
  endtask

  initial begin
    int hs, lat;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_busy",      64'(busy_o),    64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check_res("rst", 8'h00, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // Directed cases with fixed expectations.
    send(8'h5A, 8'h3C, 1'b0, 1'b0, hs);
    wait_valid(hs, lat);
    chk("c1_latency", 64'(lat), 64'(9));
    check_res("c1", 8'h96, 1'b0, 1'b1);
    release_rsp();

    send(8'hFF, 8'h01, 1'b0, 1'b0, hs);
    wait_valid(hs, lat);
    check_res("c2", 8'h00, 1'b1, 1'b0);
    release_rsp();

    send(8'h10, 8'h20, 1'b0, 1'b1, hs);
    wait_valid(hs, lat);
    check_res("c3", 8'hF0, 1'b0, 1'b0);
    release_rsp();

    send(8'h80, 8'h01, 1'b0, 1'b1, hs);
    wait_valid(hs, lat);
    check_res("c4", 8'h7F, 1'b1, 1'b1);
    release_rsp();

    // Backpressure with a competing request held valid.
    send(8'h5A, 8'h3C, 1'b0, 1'b0, hs);
    wait_valid(hs, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; a_i = W'($urandom); b_i = W'($urandom);
      cin_i = 1'($urandom); sub_i = 1'($urandom);
      @(negedge clk);
      chk("c5_req_ready_held", 64'(req_ready), 64'(0));
      chk("c5_valid_held",     64'(rsp_valid), 64'(1));
      check_res("c5_hold", 8'h96, 1'b0, 1'b1);
    end
    @(posedge clk); #1;
    a_i = 8'h11; b_i = 8'h22; cin_i = 1'b0; sub_i = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("c5_idle_ready", 64'(req_ready), 64'(1));
    chk("c5_idle_busy",  64'(busy_o),    64'(0));
    hs = cyc;
    @(posedge clk); #1 req_valid = 1'b0;
    wait_valid(hs, lat);
    chk("c5_latency", 64'(lat), 64'(9));
    check_res("c5_second", 8'h33, 1'b0, 1'b0);
    release_rsp();

    // Reset while processing bit 3.
    send(8'hA5, 8'h3C, 1'b0, 1'b0, hs);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("c6_rst_valid", 64'(rsp_valid), 64'(0));
    chk("c6_rst_busy",  64'(busy_o),    64'(0));
    chk("c6_rst_ready", 64'(req_ready), 64'(1));
    check_res("c6_rst", 8'h00, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    send(8'h01, 8'h01, 1'b0, 1'b0, hs);
    wait_valid(hs, lat);
    check_res("c6_after", 8'h02, 1'b0, 1'b0);
    release_rsp();

    // Randomized operations with random response backpressure.
    for (int n = 0; n < 40; n++) begin
      logic [W+1:0] e;
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      e  = ref_calc(ra, rb, rc, rs);
      send(ra, rb, rc, rs, hs);
      wait_valid(hs, lat);
      chk("rnd_latency", 64'(lat), 64'(9));
      check_res("rnd", e[W-1:0], e[W], e[W+1]);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      release_rsp();
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
